uo_uart_streamer: RTL

- Downstream consumer of the playground's 8-bit output bus.
- Watches an 8-bit observed value (the muxed uo_out byte) and serialises it as UART 8N1 on a single pin.
- A bench or logic analyser can log mode results without reading eight pads.
- Holds a one-entry latest-value buffer and counts values lost to overwrite.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 35 +++
 rtl/uo_uart_streamer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states and line-level constants.
// Intended for reuse by both the transmit streamer and a future receive stage.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last clock of each CLKS_PER_BIT-long bit.
// clr holds the count at zero so the next bit starts on a clean boundary.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uo_uart_streamer.sv
// Serialises the observed output byte as UART 8N1 whenever it changes or on request.
// A single latest-value buffer decouples triggers from frames; lost bytes are counted.
import uart_pkg::*;

module uo_uart_streamer #(
    parameter int CLKS_PER_BIT = 87,
    parameter int OVF_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             send_on_change,
    input  logic             force_send,
    output logic             tx,
    output logic             busy,
    output logic             pend_valid,
    output logic [OVF_W-1:0] ovf_cnt
);

    uart_state_t      state_q, state_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             pend_valid_q, pend_valid_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             tx_q, tx_d;
    logic             tick;
    logic             trigger;
    logic             consume;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clr  (state_q == IDLE),
        .tick (tick)
    );

    always_comb begin
        last_d       = data_in;
        trigger      = force_send | (send_on_change & (data_in != last_q));
        consume      = (state_q == IDLE) & pend_valid_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        tx_d         = tx_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        ovf_cnt_d    = ovf_cnt_q;

        // A new trigger beats a same-cycle consume, and that case is not an overwrite.
        if (trigger) begin
            pend_data_d  = data_in;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !consume && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    state_d = START;
                    shift_d = pend_data_q;
                    tx_d    = START_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 8'h00;
            pend_data_q  <= 8'h00;
            pend_valid_q <= 1'b0;
            ovf_cnt_q    <= '0;
            shift_q      <= 8'h00;
            bit_idx_q    <= '0;
            tx_q         <= STOP_BIT;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            ovf_cnt_q    <= ovf_cnt_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign pend_valid = pend_valid_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule
